sdram_write_engine: RTL and testbench

Responder side of the frame-store write handshake: accepts a word address on `addr` with a level `write_en` request and performs one SDRAM write burst (ACTIVE → WRITE → PRECHARGE). It then returns a one-cycle `write_ack`. It also services auto-refresh requests between bursts. It sits between the capture-side write controller and the SDRAM pins; the power-up init sequencer owns the bus until `init_done`.

---
 rtl/sdram_write_engine.sv | 158 +++++++++++++++
 tb/tb_sdram_write_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_engine.sv
// SDRAM write-burst engine: ACTIVE -> WRITE burst -> PRECHARGE per request, plus
// auto-refresh between bursts. Every output is a register; one shared down-counter times each state.
module sdram_write_engine #(
  parameter int BURST_LEN = 8,
  parameter int TRCD      = 2,
  parameter int TWR       = 2,
  parameter int TRP       = 2,
  parameter int TRFC      = 7
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        init_done,
  input  logic        write_en,
  input  logic [19:0] addr,
  output logic        write_ack,
  output logic        wr_data_req,
  input  logic [15:0] wr_data,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        busy,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic [1:0]  sdram_dqm
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  // Counter reload values: a state lasting N cycles loads N-1. WR_RECOV holds
  // TWR-1 cycles because the PRECHARGE cycle itself completes the recovery time.
  localparam logic [8:0] TRCD_LD  = 9'(TRCD - 1);
  localparam logic [8:0] BURST_LD = 9'(BURST_LEN - 1);
  localparam logic [8:0] TWR_LD   = 9'((TWR > 1) ? TWR - 2 : 0);
  localparam logic [8:0] TRP_LD   = 9'(TRP - 1);
  localparam logic [8:0] TRFC_LD  = 9'(TRFC - 1);

  typedef enum logic [2:0] {
    IDLE, ACT_WAIT, WRITE_DATA, WR_RECOV, PRE_WAIT, ACK, REF_WAIT
  } state_t;

  state_t      state_reg;
  logic [8:0]  cnt_reg;
  logic [1:0]  bank_reg;
  logic [7:0]  col_reg;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bank_reg     <= '0;
      col_reg      <= '0;
      write_ack    <= 1'b0;
      ref_ack      <= 1'b0;
      wr_data_req  <= 1'b0;
      busy         <= 1'b0;
      sdram_cke    <= 1'b1;
      sdram_cmd    <= CMD_NOP;
      sdram_ba     <= '0;
      sdram_addr   <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
      sdram_dqm    <= '0;
    end else begin
      sdram_cmd   <= CMD_NOP;
      write_ack   <= 1'b0;
      ref_ack     <= 1'b0;
      // The word pulled on a request cycle goes onto the bus the following cycle.
      sdram_dq_oe <= wr_data_req;
      if (wr_data_req) sdram_dq_out <= wr_data;
      if (cnt_reg != 9'd0) cnt_reg <= cnt_reg - 9'd1;

      case (state_reg)
        IDLE: begin
          if (init_done) begin
            if (ref_req) begin
              sdram_cmd <= CMD_REF;
              cnt_reg   <= TRFC_LD;
              busy      <= 1'b1;
              state_reg <= REF_WAIT;
            end else if (write_en) begin
              bank_reg    <= addr[19:18];
              col_reg     <= addr[7:0];
              sdram_cmd   <= CMD_ACT;
              sdram_ba    <= addr[19:18];
              sdram_addr  <= {2'b00, addr[17:8]};
              cnt_reg     <= TRCD_LD;
              busy        <= 1'b1;
              wr_data_req <= (TRCD == 1);
              state_reg   <= ACT_WAIT;
            end
          end
        end
        ACT_WAIT: begin
          if (cnt_reg == 9'd0) begin
            sdram_cmd   <= CMD_WR;
            sdram_ba    <= bank_reg;
            sdram_addr  <= {4'b0000, col_reg};
            cnt_reg     <= BURST_LD;
            wr_data_req <= (BURST_LEN > 1);
            state_reg   <= WRITE_DATA;
          end else begin
            wr_data_req <= (cnt_reg == 9'd1);
          end
        end
        WRITE_DATA: begin
          wr_data_req <= (cnt_reg >= 9'd2);
          if (cnt_reg == 9'd0) begin
            if (TWR == 1) begin
              sdram_cmd  <= CMD_PRE;
              sdram_addr <= 12'h400;
              cnt_reg    <= TRP_LD;
              state_reg  <= PRE_WAIT;
            end else begin
              cnt_reg    <= TWR_LD;
              state_reg  <= WR_RECOV;
            end
          end
        end
        WR_RECOV: begin
          if (cnt_reg == 9'd0) begin
            sdram_cmd  <= CMD_PRE;
            sdram_addr <= 12'h400;
            cnt_reg    <= TRP_LD;
            state_reg  <= PRE_WAIT;
          end
        end
        PRE_WAIT: begin
          if (cnt_reg == 9'd0) begin
            write_ack <= 1'b1;
            state_reg <= ACK;
          end
        end
        REF_WAIT: begin
          if (cnt_reg == 9'd0) begin
            ref_ack   <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_engine.sv
// Bench for sdram_write_engine: directed address table, multi-cycle corner cases,
// then random writes/refreshes checked cycle by cycle against timing formulas.
module tb_sdram_write_engine;

  localparam int BURST_LEN = 8;
  localparam int TRCD      = 2;
  localparam int TWR       = 2;
  localparam int TRP       = 2;
  localparam int TRFC      = 7;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  logic        S_CLK;
  logic        RST_N;
  logic        init_done;
  logic        write_en;
  logic [19:0] addr;
  logic        write_ack;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        ref_req;
  logic        ref_ack;
  logic        busy;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [1:0]  sdram_dqm;

  sdram_write_engine #(
    .BURST_LEN(BURST_LEN), .TRCD(TRCD), .TWR(TWR), .TRP(TRP), .TRFC(TRFC)
  ) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .init_done(init_done), .write_en(write_en),
    .addr(addr), .write_ack(write_ack), .wr_data_req(wr_data_req), .wr_data(wr_data),
    .ref_req(ref_req), .ref_ack(ref_ack), .busy(busy), .sdram_cke(sdram_cke),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .sdram_dqm(sdram_dqm)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  // FWFT source: head word shown on wr_data, advanced on every request edge.
  logic [15:0] data_mem [0:255];
  logic [31:0] src_idx = 32'd0;
  always @(posedge S_CLK) if (wr_data_req) src_idx <= src_idx + 32'd1;
  assign wr_data = data_mem[src_idx[7:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  typedef struct {
    logic [19:0] a;
    logic [1:0]  ba;
    logic [11:0] row;
    logic [11:0] col;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cmd"}, sdram_cmd, NOP);
    chk({tag, " cke"}, sdram_cke, 1);
    chk({tag, " ba"}, sdram_ba, 0);
    chk({tag, " addr"}, sdram_addr, 0);
    chk({tag, " dq"}, sdram_dq_out, 0);
    chk({tag, " oe"}, sdram_dq_oe, 0);
    chk({tag, " dqm"}, sdram_dqm, 0);
    chk({tag, " wack"}, write_ack, 0);
    chk({tag, " rack"}, ref_ack, 0);
    chk({tag, " req"}, wr_data_req, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // Called at an IDLE cycle; that cycle is cycle 0. Ends at the IDLE cycle after the ack.
  task automatic do_write(input logic [19:0] a, input logic [1:0] eb, input logic [11:0] erow,
                          input logic [11:0] ecol, input int ref_at);
    int L, last, base, bad0, k;
    logic [3:0] ec;
    logic eo;
    string t;
    L = TRCD + BURST_LEN;
    last = L + TWR + TRP;
    base = int'(src_idx);
    bad0 = n_bad;
    txn++;
    addr = a;
    write_en = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge S_CLK); #1;
      t = $sformatf("w%0d c%0d", txn, c);
      if (c == 2) addr = ~a;
      ec = NOP;
      if (c == 1) ec = ACT;
      else if (c == 1 + TRCD) ec = WRC;
      else if (c == L + TWR) ec = PRE;
      eo = (c >= TRCD + 1) && (c <= L);
      chk({t, " cmd"}, sdram_cmd, ec);
      chk({t, " busy"}, busy, (c >= 1) && (c <= last));
      chk({t, " wack"}, write_ack, c == last);
      chk({t, " rack"}, ref_ack, 0);
      chk({t, " req"}, wr_data_req, (c >= TRCD) && (c <= L - 1));
      chk({t, " oe"}, sdram_dq_oe, eo);
      chk({t, " dqm"}, sdram_dqm, 0);
      chk({t, " cke"}, sdram_cke, 1);
      if (eo) begin
        k = c - 1 - TRCD;
        chk({t, " dq"}, sdram_dq_out, data_mem[(base + k) % 256]);
      end
      if (ec == ACT) begin
        chk({t, " act ba"}, sdram_ba, eb);
        chk({t, " act row"}, sdram_addr, erow);
      end
      if (ec == WRC) begin
        chk({t, " wr ba"}, sdram_ba, eb);
        chk({t, " wr col"}, sdram_addr, ecol);
      end
      if (ec == PRE) chk({t, " pre a10"}, sdram_addr[10], 1);
      if (c == last) write_en = 1'b0;
      if (c == ref_at) ref_req = 1'b1;
    end
    $display("txn %0d write addr=%05h ba=%0d row=%03h col=%02h errors=%0d",
             txn, a, eb, erow, ecol, n_bad - bad0);
  endtask

  // Called at an IDLE cycle with ref_req about to be sampled; ends at the IDLE cycle after ref_ack.
  task automatic do_refresh();
    int bad0;
    string t;
    bad0 = n_bad;
    txn++;
    ref_req = 1'b1;
    for (int c = 1; c <= TRFC + 2; c++) begin
      @(posedge S_CLK); #1;
      t = $sformatf("r%0d c%0d", txn, c);
      chk({t, " cmd"}, sdram_cmd, (c == 1) ? REF : NOP);
      chk({t, " rack"}, ref_ack, c == TRFC + 1);
      chk({t, " wack"}, write_ack, 0);
      chk({t, " busy"}, busy, c <= TRFC + 1);
      chk({t, " oe"}, sdram_dq_oe, 0);
      chk({t, " req"}, wr_data_req, 0);
      if (c == TRFC + 1) ref_req = 1'b0;
    end
    $display("txn %0d refresh errors=%0d", txn, n_bad - bad0);
  endtask

  task automatic idle_cycles(input int n);
    write_en = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge S_CLK); #1;
      chk("idle cmd", sdram_cmd, NOP);
      chk("idle busy", busy, 0);
    end
  endtask

  initial begin
    logic [19:0] ra;
    int sel, bad0;

    for (int i = 0; i < 256; i++) data_mem[i] = (i < 8) ? 16'(i) : 16'($urandom);
    vecs[0] = '{20'hC1234, 2'd3, 12'h012, 12'h034};
    vecs[1] = '{20'h00000, 2'd0, 12'h000, 12'h000};
    vecs[2] = '{20'hFFFFF, 2'd3, 12'h3FF, 12'h0FF};
    vecs[3] = '{20'h5A5C3, 2'd1, 12'h1A5, 12'h0C3};
    vecs[4] = '{20'h3FF00, 2'd0, 12'h3FF, 12'h000};
    vecs[5] = '{20'h80001, 2'd2, 12'h000, 12'h001};

    RST_N = 1'b0; init_done = 1'b0; write_en = 1'b0; ref_req = 1'b0; addr = '0;
    repeat (3) @(posedge S_CLK);
    #1;
    chk_reset("reset");
    RST_N = 1'b1;

    // Init gating: requests are ignored until init_done.
    write_en = 1'b1;
    addr = 20'hC1234;
    for (int c = 0; c < 20; c++) begin
      @(posedge S_CLK); #1;
      chk("gate cmd", sdram_cmd, NOP);
      chk("gate busy", busy, 0);
    end
    $display("txn 0 init gating checked for 20 cycles");
    init_done = 1'b1;

    foreach (vecs[i]) begin
      do_write(vecs[i].a, vecs[i].ba, vecs[i].row, vecs[i].col, -1);
      idle_cycles(1);
    end

    // Refresh and write requested together: refresh first, ACTIVE 2 cycles after ref_ack.
    write_en = 1'b1;
    do_refresh();
    do_write(20'h4ABCD, 2'd1, 12'h0AB, 12'h0CD, -1);

    // Refresh rising mid-burst is served right after the ack.
    do_write(20'h2F0F0, 2'd0, 12'h2F0, 12'h0F0, 5);
    do_refresh();
    idle_cycles(2);

    // Reset at cycle 6 of a burst.
    bad0 = n_bad;
    txn++;
    addr = 20'h91357;
    write_en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge S_CLK); #1;
    end
    RST_N = 1'b0;
    #1;
    chk_reset("mid-rst now");
    write_en = 1'b0;
    @(posedge S_CLK); #1;
    chk_reset("mid-rst held");
    RST_N = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge S_CLK); #1;
      chk("post-rst wack", write_ack, 0);
      chk("post-rst busy", busy, 0);
    end
    $display("txn %0d reset mid-burst errors=%0d", txn, n_bad - bad0);
    do_write(20'h91357, 2'd2, 12'h113, 12'h057, -1);

    // Random traffic against the timing-formula model.
    for (int n = 0; n < 24; n++) begin
      ra = 20'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        write_en = 1'b1;
        addr = ra;
        do_refresh();
        do_write(ra, ra[19:18], {2'b00, ra[17:8]}, {4'b0000, ra[7:0]}, -1);
      end else if (sel < 4) begin
        do_write(ra, ra[19:18], {2'b00, ra[17:8]}, {4'b0000, ra[7:0]},
                 $urandom_range(1, TRCD + BURST_LEN + TWR + TRP - 1));
        do_refresh();
      end else begin
        do_write(ra, ra[19:18], {2'b00, ra[17:8]}, {4'b0000, ra[7:0]}, -1);
      end
      idle_cycles($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
